// File: rtl/ssd_scan_controller.sv
// -----------------------------------------------------------------------------
// ssd_scan_controller
//
// Time-multiplexed scan controller for a 4-digit seven-segment display.
// Each digit gets BLANK_CYCLES of all-dark dead time, then DIGIT_CYCLES lit.
// The value on screen (shown) is updated only at frame boundaries, from a
// staging register written by load. This keeps a new value from tearing
// mid-frame.
//
// Parameters:
//   DIGIT_CYCLES  cycles each digit is lit (>= 1)
//   BLANK_CYCLES  dark cycles before each digit (>= 1)
//
// Ports:
//   clk         system clock, rising edge
//   rst         asynchronous, active-high reset
//   value[15:0] hex value; nibble k is shown on digit k
//   load        one-cycle strobe; captures value into the staging register
//   dot_en[3:0] per-digit decimal point request (bit k = digit k)
//   lead_blank  1 = suppress leading-zero digits (sampled live)
//   select[1:0] index of the current digit
//   digit_en[3:0] one-hot active-high digit enable; 0000 while dark
//   seg[6:0]    active-low segments {g,f,e,d,c,b,a}
//   dot         active-low decimal point
//   frame_done  one-cycle pulse at each frame boundary
//   pending     staged value not yet displayed
// -----------------------------------------------------------------------------
module ssd_scan_controller #(
  parameter int DIGIT_CYCLES = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] value,
  input  logic        load,
  input  logic [3:0]  dot_en,
  input  logic        lead_blank,
  output logic [1:0]  select,
  output logic [3:0]  digit_en,
  output logic [6:0]  seg,
  output logic        dot,
  output logic        frame_done,
  output logic        pending
);

  localparam int CNT_MAX = (DIGIT_CYCLES > BLANK_CYCLES) ? DIGIT_CYCLES : BLANK_CYCLES;
  // The counter only has to reach CNT_MAX-1.
  localparam int CNT_W = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIGIT_LAST = CNT_W'(DIGIT_CYCLES - 1);

  localparam logic [6:0] SEG_DARK = 7'h7F;

  typedef enum logic {
    BLANK = 1'b0,
    LIT   = 1'b1
  } state_t;

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic [1:0]       select_next;
  logic             boundary;

  logic [15:0]      staged, shown;

  logic             lit_next;
  logic [3:0]       digit_en_next;
  logic [6:0]       seg_next;
  logic             dot_next;

  function automatic logic [6:0] encode(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  // Digit k (k >= 1) is a leading zero when nibbles k..3 are all zero.
  // Digit 0 is always displayed.
  function automatic logic suppressed(input logic [1:0] k, input logic [15:0] v,
                                      input logic lb);
    logic z;
    case (k)
      2'd1:    z = (v[15:4]  == 12'h000);
      2'd2:    z = (v[15:8]  == 8'h00);
      2'd3:    z = (v[15:12] == 4'h0);
      default: z = 1'b0;
    endcase
    return lb & z;
  endfunction

  // ---------------------------------------------------------------------------
  // Next-state logic. Select advances only on LIT->BLANK, so it is stable
  // across both phases of a digit.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    state_next  = state;
    cnt_next    = cnt + CNT_W'(1);
    select_next = select;
    boundary    = 1'b0;
    case (state)
      BLANK: begin
        if (cnt == BLANK_LAST) begin
          state_next = LIT;
          cnt_next   = '0;
        end
      end
      LIT: begin
        if (cnt == DIGIT_LAST) begin
          state_next  = BLANK;
          cnt_next    = '0;
          select_next = select + 2'd1;
          boundary    = (select == 2'd3);
        end
      end
      default: begin
        state_next = BLANK;
        cnt_next   = '0;
      end
    endcase
  end

  // Display outputs are registered from the next state, so they change on the
  // same edge as the transition that causes them. shown never changes while
  // entering or staying in LIT, so using its current value is safe here.
  always_comb begin
    lit_next      = (state_next == LIT) && !suppressed(select_next, shown, lead_blank);
    digit_en_next = 4'b0000;
    seg_next      = SEG_DARK;
    dot_next      = 1'b1;
    if (lit_next) begin
      digit_en_next = 4'b0001 << select_next;
      seg_next      = encode(shown[{select_next, 2'b00} +: 4]);
      dot_next      = ~dot_en[select_next];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values computed above, regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= BLANK;
      cnt    <= '0;
      select <= 2'd0;
    end else begin
      state  <= state_next;
      cnt    <= cnt_next;
      select <= select_next;
    end
  end

  // Double buffer. On a boundary edge shown takes the pre-edge staged value,
  // so a coincident load waits a full frame and keeps pending set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      staged     <= 16'h0000;
      shown      <= 16'h0000;
      pending    <= 1'b0;
      frame_done <= 1'b0;
      digit_en   <= 4'b0000;
      seg        <= SEG_DARK;
      dot        <= 1'b1;
    end else begin
      if (load) begin
        staged <= value;
      end
      if (boundary) begin
        shown   <= staged;
        pending <= load;
      end else if (load) begin
        pending <= 1'b1;
      end
      frame_done <= boundary;
      digit_en   <= digit_en_next;
      seg        <= seg_next;
      dot        <= dot_next;
    end
  end

endmodule

// File: tb/tb_ssd_scan_controller.sv
// -----------------------------------------------------------------------------
// tb_ssd_scan_controller
//
// Bench for ssd_scan_controller with DIGIT_CYCLES=4, BLANK_CYCLES=2
// (digit period 6, frame 24). The reference model tracks the edge count n
// since reset release. After edge n the current digit is (n/6)%4, and it is
// lit when n%6 >= 2. Frame boundaries fall on edges where n%24 == 0.
// -----------------------------------------------------------------------------
module tb_ssd_scan_controller;

  localparam int DIGIT_CYCLES = 4;
  localparam int BLANK_CYCLES = 2;
  localparam int DIGIT_PERIOD = DIGIT_CYCLES + BLANK_CYCLES;
  localparam int FRAME        = 4 * DIGIT_PERIOD;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] value = 16'h0000;
  logic        load = 1'b0;
  logic [3:0]  dot_en = 4'b0000;
  logic        lead_blank = 1'b0;
  logic [1:0]  select;
  logic [3:0]  digit_en;
  logic [6:0]  seg;
  logic        dot;
  logic        frame_done;
  logic        pending;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int          m_n = 0;
  logic [15:0] m_staged = 16'h0000;
  logic [15:0] m_shown  = 16'h0000;
  logic        m_pending = 1'b0;
  logic [6:0]  seg_tab [16];

  ssd_scan_controller #(
    .DIGIT_CYCLES(DIGIT_CYCLES),
    .BLANK_CYCLES(BLANK_CYCLES)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .value      (value),
    .load       (load),
    .dot_en     (dot_en),
    .lead_blank (lead_blank),
    .select     (select),
    .digit_en   (digit_en),
    .seg        (seg),
    .dot        (dot),
    .frame_done (frame_done),
    .pending    (pending)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s at edge %0d: observed=%h expected=%h", tag, m_n, obs, exp);
    end
  endtask

  // One clock edge with the given load/value; dot_en and lead_blank are used
  // as currently driven. Called at a falling edge; checks at the next one.
  task automatic step(input logic ld, input logic [15:0] v);
    logic        lb;
    logic [3:0]  de;
    int          d;
    logic        lit;
    logic [15:0] upper;
    logic [3:0]  exp_en;
    logic [6:0]  exp_seg;
    logic        exp_dot;
    load  = ld;
    value = v;
    lb    = lead_blank;
    de    = dot_en;
    @(posedge clk);
    m_n++;
    if (m_n % FRAME == 0) begin
      m_shown   = m_staged;
      m_pending = ld;
    end else if (ld) begin
      m_pending = 1'b1;
    end
    if (ld) m_staged = v;

    d     = (m_n / DIGIT_PERIOD) % 4;
    lit   = (m_n % DIGIT_PERIOD) >= BLANK_CYCLES;
    upper = m_shown >> (4 * d);
    if (lit && lb && d > 0 && upper == 16'h0000) lit = 1'b0;
    exp_en  = lit ? 4'(1 << d) : 4'b0000;
    exp_seg = lit ? seg_tab[upper[3:0]] : 7'h7F;
    exp_dot = lit ? ~de[d] : 1'b1;

    @(negedge clk);
    load = 1'b0;
    check("select",     16'(select),     16'(d));
    check("digit_en",   16'(digit_en),   16'(exp_en));
    check("seg",        16'(seg),        16'(exp_seg));
    check("dot",        16'(dot),        16'(exp_dot));
    check("frame_done", 16'(frame_done), 16'(m_n % FRAME == 0));
    check("pending",    16'(pending),    16'(m_pending));
  endtask

  task automatic idle_to(input int target);
    while (m_n < target) step(1'b0, 16'h0000);
  endtask

  task automatic check_dark(input string tag);
    check({tag, "_select"},     16'(select),     16'h0);
    check({tag, "_digit_en"},   16'(digit_en),   16'h0);
    check({tag, "_seg"},        16'(seg),        16'h7F);
    check({tag, "_dot"},        16'(dot),        16'h1);
    check({tag, "_frame_done"}, 16'(frame_done), 16'h0);
    check({tag, "_pending"},    16'(pending),    16'h0);
  endtask

  // Hold reset for a full cycle, check reset values, release at a falling edge.
  task automatic do_reset();
    @(negedge clk);
    rst        = 1'b1;
    load       = 1'b0;
    dot_en     = 4'b0000;
    lead_blank = 1'b0;
    #1;
    check_dark("reset");
    @(negedge clk);
    rst       = 1'b0;
    m_n       = 0;
    m_staged  = 16'h0000;
    m_shown   = 16'h0000;
    m_pending = 1'b0;
  endtask

  initial begin
    seg_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    // 1. Reset release and first digit timing
    do_reset();
    step(1'b0, 16'h0000);
    check("t1_e1_digit_en", 16'(digit_en), 16'h0);
    check("t1_e1_seg",      16'(seg),      16'h7F);
    step(1'b0, 16'h0000);
    check("t1_e2_digit_en", 16'(digit_en), 16'h1);
    check("t1_e2_seg",      16'(seg),      16'h40);
    check("t1_e2_select",   16'(select),   16'h0);
    idle_to(4);

    // 2. Load at edge 5, visible in the frame after edge 24
    step(1'b1, 16'h1A2F);
    check("t2_e5_pending", 16'(pending), 16'h1);
    check("t2_e5_seg",     16'(seg),     16'h40);
    idle_to(6);
    check("t1_e6_digit_en", 16'(digit_en), 16'h0);
    check("t1_e6_select",   16'(select),   16'h1);
    idle_to(24);
    check("t2_e24_frame_done", 16'(frame_done), 16'h1);
    check("t2_e24_pending",    16'(pending),    16'h0);
    idle_to(26); check("t2_d0_seg", 16'(seg), 16'h0E);
    idle_to(32); check("t2_d1_seg", 16'(seg), 16'h24);
    idle_to(38); check("t2_d2_seg", 16'(seg), 16'h08);
    idle_to(44); check("t2_d3_seg", 16'(seg), 16'h79);
    idle_to(48);

    // 3. Leading-zero blanking
    do_reset();
    lead_blank = 1'b1;
    idle_to(4);
    step(1'b1, 16'h0007);
    idle_to(26); check("t3_d0_seg", 16'(seg), 16'h78);
    check("t3_d0_en", 16'(digit_en), 16'h1);
    idle_to(32); check("t3_d1_en", 16'(digit_en), 16'h0);
    idle_to(38); check("t3_d2_en", 16'(digit_en), 16'h0);
    idle_to(44); check("t3_d3_en", 16'(digit_en), 16'h0);
    idle_to(49);
    step(1'b1, 16'h0000);
    idle_to(74); check("t3_zero_d0_seg", 16'(seg), 16'h40);
    check("t3_zero_d0_en", 16'(digit_en), 16'h1);
    idle_to(80); check("t3_zero_d1_en", 16'(digit_en), 16'h0);
    idle_to(96);
    lead_blank = 1'b0;

    // 4. Load coincident with the boundary waits a frame
    do_reset();
    idle_to(4);
    step(1'b1, 16'h1111);
    idle_to(23);
    step(1'b1, 16'h2222);
    check("t4_e24_pending", 16'(pending), 16'h1);
    idle_to(26); check("t4_f1_d0", 16'(seg), 16'h79);
    idle_to(32); check("t4_f1_d1", 16'(seg), 16'h79);
    idle_to(38); check("t4_f1_d2", 16'(seg), 16'h79);
    idle_to(44); check("t4_f1_d3", 16'(seg), 16'h79);
    check("t4_f1_pending", 16'(pending), 16'h1);
    idle_to(48); check("t4_e48_pending", 16'(pending), 16'h0);
    idle_to(50); check("t4_f2_d0", 16'(seg), 16'h24);
    idle_to(56); check("t4_f2_d1", 16'(seg), 16'h24);
    idle_to(62); check("t4_f2_d2", 16'(seg), 16'h24);
    idle_to(68); check("t4_f2_d3", 16'(seg), 16'h24);

    // 5. Decimal point only on digit 2
    dot_en = 4'b0100;
    idle_to(80); check("t5_d1_dot", 16'(dot), 16'h1);
    idle_to(86); check("t5_d2_dot", 16'(dot), 16'h0);
    idle_to(96);
    dot_en = 4'b0000;

    // 6. Randomized loads, dots and blanking against the model
    for (int i = 0; i < 300; i++) begin
      logic        ld;
      logic [15:0] v;
      ld = ($urandom_range(0, 7) == 0);
      v  = 16'($urandom) >> (4 * $urandom_range(0, 4));
      if ($urandom_range(0, 15) == 0) dot_en = 4'($urandom);
      if ($urandom_range(0, 15) == 0) lead_blank = 1'($urandom);
      step(ld, v);
    end
    dot_en     = 4'b0000;
    lead_blank = 1'b0;

    // 7. Asynchronous reset during digit 2 LIT
    do_reset();
    idle_to(4);
    step(1'b1, 16'h3456);
    idle_to(FRAME + 15);
    check("t7_pre_en", 16'(digit_en), 16'h4);
    #2 rst = 1'b1;
    #1;
    check_dark("t7_async");
    @(negedge clk);
    rst       = 1'b0;
    m_n       = 0;
    m_staged  = 16'h0000;
    m_shown   = 16'h0000;
    m_pending = 1'b0;
    idle_to(2);
    check("t7_first_lit_seg", 16'(seg),      16'h40);
    check("t7_first_lit_en",  16'(digit_en), 16'h1);
    idle_to(6);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Hard time limit in case the bench stalls.
  initial begin
    #200000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/ssd_scan_controller.md
# ssd_scan_controller

Time-multiplexed scan controller for the 4-digit seven-segment display. It holds a 16-bit hex value and steps a 2-bit digit select through digits 0..3, driving the digit-enable lines and the active-low segments of one digit at a time. A dead-time blank between digits prevents ghosting. Display updates are double-buffered, so a new value never tears mid-frame.

## Interface
- DIGIT_CYCLES, 50000, clock cycles each digit is lit (≥1)
- BLANK_CYCLES, 500, clock cycles of all-dark dead time before each digit (≥1)

- Clock  input  1  system clock, rising edge
- Reset  input  1  asynchronous, active-high
- Value  input  16  hex value; nibble k is shown on digit k (digit 0 = least significant)
- Load  input  1  one-cycle strobe; captures Value into the staging register
- Dot_En  input  4  per-digit decimal point request, bit k = digit k
- Lead_Blank  input  1  1 = suppress leading-zero digits
- Select  output  2  index of the current digit
- Digit_En  output  4  one-hot, active-high digit enable (bit k = digit k); 0000 while dark
- Seg  output  7  active-low segments {g,f,e,d,c,b,a}
- Dot  output  1  active-low decimal point
- Frame_Done  output  1  one-cycle pulse at each frame boundary
- Pending  output  1  staged value not yet displayed

## Operation
- Registers: Staged[15:0], Shown[15:0], state {BLANK, LIT}, Select, cycle counter sized for max(DIGIT_CYCLES, BLANK_CYCLES).
- Reset values (applied asynchronously):
  - state = BLANK, counter = 0, Select = 0
  - Staged = Shown = 0, Pending = 0
  - Digit_En = 0000, Seg = 7'h7F, Dot = 1, Frame_Done = 0
- BLANK state: Digit_En = 0000, Seg = 7'h7F, Dot = 1. After BLANK_CYCLES cycles, go to LIT and clear the counter.
- LIT state:
  - Digit_En = one-hot(Select).
  - Seg = encode(Shown[4*Select +: 4]).
  - Dot = ~Dot_En[Select].
  - After DIGIT_CYCLES cycles, go to BLANK and set Select = Select+1 mod 4.
- Frame boundary: the LIT→BLANK edge with Select==3. On this edge:
  - Select wraps to 0.
  - Shown <= Staged (value before the edge).
  - Frame_Done = 1 for exactly one cycle.
  - Pending <= Load.
- Load handling:
  - Load=1 at any edge sets Staged <= Value and Pending <= 1.
  - Multiple Loads within one frame: the last one wins.
  - Load on the boundary edge: Shown takes the old Staged; the new value waits for the next frame, and Pending stays 1.
- Leading blank: with Lead_Blank=1, digit k (k≥1) is suppressed if Shown nibbles k..3 are all zero.
  - A suppressed digit behaves as BLANK for its LIT period: Digit_En=0000, Seg=7'h7F, Dot=1.
  - Digit 0 is never suppressed.
  - Lead_Blank is sampled live.
- Segment encoding, 0..F: 40,79,24,30,19,12,02,78,00,10,08,03,46,21,06,0E (hex).

## Timing
- All outputs are flops and change on the same edge as the state/Select transition that causes them.
- Digit period is BLANK_CYCLES+DIGIT_CYCLES cycles; frame period is 4× that.
- Select is stable across the BLANK and LIT phases of a digit. It only changes on a LIT→BLANK edge, while Digit_En goes to 0000 on that same edge.
- Two digits are never enabled in consecutive cycles. At least BLANK_CYCLES dark cycles separate them.
- Load-to-visible latency is at most one frame plus one digit period.
- Reset asserted mid-operation takes effect immediately, without waiting for a clock edge. After deassertion the sequence restarts at BLANK for digit 0.

## Test plan
Benches use DIGIT_CYCLES=4, BLANK_CYCLES=2, so digit period = 6 and frame = 24. Edge n means the nth rising edge after Reset deasserts, starting at 1.

- Reset release → Digit_En=0000 and Seg=7'h7F for 2 cycles. At edge 2: Digit_En=0001, Seg=7'h40, Select=0. At edge 6: Digit_En=0000, Select=1.
- Load=1 with Value=16'h1A2F at edge 5 → Pending=1 and digit 0 keeps showing 7'h40. At edge 24: Frame_Done pulses and Pending=0. The next frame shows digit0 7'h0E, digit1 7'h24, digit2 7'h08, digit3 7'h79.
- Lead_Blank=1, Value=16'h0007 loaded → digits 3, 2, 1 stay at 0000 for their LIT periods, and digit 0 shows 7'h78. Loading 16'h0000 instead → only digit 0 lit, showing 7'h40.
- Load 16'h1111 at edge 5, then Load 16'h2222 coincident with edge 24 → the frame after edge 24 shows all 7'h79 and Pending stays 1. The frame after edge 48 shows all 7'h24 and Pending=0.
- Dot_En=4'b0100 → Dot=0 only while Digit_En=0100; Dot=1 at all other times.
- Reset asserted during digit 2 LIT → immediately Digit_En=0000, Seg=7'h7F, Select=0, Pending=0, Shown=0. After release the first LIT shows 7'h40.
